// File: rtl/mac_seq_pkg.sv
// Shared types and default widths for the MAC sequencing controller.
// Consumed by mac_seq_ctrl and its bus interface.
package mac_seq_pkg;

    localparam int BW      = 4;
    localparam int PSUM_BW = 16;
    localparam int LEN_BW  = 8;
    localparam int LANES   = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/mac_seq_ctrl_if.sv
// Bus bundle between operand fetch, the MAC datapath and the result consumer.
// The controller takes the slave side; the surrounding logic takes the master side.
interface mac_seq_ctrl_if;
    import mac_seq_pkg::*;

    logic                     start;
    logic [LEN_BW-1:0]        len;
    logic                     busy;
    logic                     in_valid;
    logic                     in_ready;
    logic [LANES*BW-1:0]      in_x;
    logic [LANES*BW-1:0]      in_w;
    logic [LANES*BW-1:0]      mac_x;
    logic [LANES*BW-1:0]      mac_w;
    logic [PSUM_BW-1:0]       mac_psum;
    logic [PSUM_BW-1:0]       mac_out;
    logic                     out_valid;
    logic                     out_ready;
    logic [PSUM_BW-1:0]       out_data;

    modport master (
        output start, len, in_valid, in_x, in_w, mac_out, out_ready,
        input  busy, in_ready, mac_x, mac_w, mac_psum, out_valid, out_data
    );

    modport slave (
        input  start, len, in_valid, in_x, in_w, mac_out, out_ready,
        output busy, in_ready, mac_x, mac_w, mac_psum, out_valid, out_data
    );

endinterface

// File: rtl/mac_seq_ctrl.sv
// Sequences chunked dot products through the external 4-lane MAC datapath.
// Optional MAC_SEQ_BIAS_EN adds a bias port that seeds the accumulator.
//
// state    | meaning
// ST_IDLE  | waiting for start; len/bias sampled here
// ST_RUN   | accepting chunks, one per cycle on handshake
// ST_DRAIN | last chunk on the datapath, final capture into acc
// ST_DONE  | result held on out_data until out_ready
module mac_seq_ctrl
    import mac_seq_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
`ifdef MAC_SEQ_BIAS_EN
    input  logic [PSUM_BW-1:0]  bias,
`endif
    mac_seq_ctrl_if.slave       bus
);

    state_t               state;
    logic [LEN_BW-1:0]    remaining;
    logic                 stage_valid;
    logic [PSUM_BW-1:0]   acc;
    logic [PSUM_BW-1:0]   acc_init;
    logic [LANES*BW-1:0]  mac_x;
    logic [LANES*BW-1:0]  mac_w;
    logic                 busy;
    logic                 in_ready;
    logic                 out_valid;
    logic                 handshake;

`ifdef MAC_SEQ_BIAS_EN
    assign acc_init = bias;
`else
    assign acc_init = '0;
`endif

    // in_ready is registered and only high in ST_RUN, so it doubles as the state qualifier
    assign handshake = in_ready & bus.in_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            remaining   <= '0;
            stage_valid <= 1'b0;
            acc         <= '0;
            mac_x       <= '0;
            mac_w       <= '0;
            busy        <= 1'b0;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
        end else begin
            if (stage_valid) begin
                acc <= bus.mac_out;
            end
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        remaining <= bus.len;
                        acc       <= acc_init;
                        busy      <= 1'b1;
                        if (bus.len != '0) begin
                            state    <= ST_RUN;
                            in_ready <= 1'b1;
                        end else begin
                            state     <= ST_DONE;
                            out_valid <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (handshake) begin
                        mac_x       <= bus.in_x;
                        mac_w       <= bus.in_w;
                        stage_valid <= 1'b1;
                        remaining   <= remaining - 1'b1;
                        if (remaining == LEN_BW'(1)) begin
                            state    <= ST_DRAIN;
                            in_ready <= 1'b0;
                        end
                    end else begin
                        stage_valid <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    stage_valid <= 1'b0;
                    state       <= ST_DONE;
                    out_valid   <= 1'b1;
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy;
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_valid ? acc : '0;
    assign bus.mac_x     = mac_x;
    assign bus.mac_w     = mac_w;
    assign bus.mac_psum  = acc;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl: datapath model, cycle-level job model and directed plus random jobs.
module tb_mac_seq_ctrl;

    logic        clk;
    logic        reset;
    logic [15:0] tb_bias;

    mac_seq_ctrl_if bus ();

    mac_seq_ctrl dut (
        .clk   (clk),
        .reset (reset),
`ifdef MAC_SEQ_BIAS_EN
        .bias  (tb_bias),
`endif
        .bus   (bus)
    );

    int total;
    int bad;
    bit chk_en;

    logic [15:0] cx [0:15];
    logic [15:0] cw [0:15];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] dot(input logic [15:0] x, input logic [15:0] w);
        int s;
        s = 0;
        for (int i = 0; i < 4; i++)
            s += int'(x[i*4 +: 4]) * int'($signed(w[i*4 +: 4]));
        return s[15:0];
    endfunction

    // External combinational datapath
    always_comb bus.mac_out = bus.mac_psum + dot(bus.mac_x, bus.mac_w);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Job-level model: acc tracks sums of chunks accepted two or more edges ago
    logic [15:0] m_acc, m_pend_dot, m_x, m_w;
    bit          m_pend, m_busy, m_outv, m_drain;
    int          m_left;

    function automatic logic [15:0] init_val();
`ifdef MAC_SEQ_BIAS_EN
        return tb_bias;
`else
        return 16'h0000;
`endif
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_acc = '0; m_pend_dot = '0; m_x = '0; m_w = '0;
            m_pend = 0; m_busy = 0; m_outv = 0; m_drain = 0; m_left = 0;
        end else begin
            if (m_pend) m_acc = m_acc + m_pend_dot;
            m_pend = 0;
            if (!m_busy) begin
                if (bus.start) begin
                    m_busy = 1;
                    m_acc  = init_val();
                    m_left = int'(bus.len);
                    if (m_left == 0) m_outv = 1;
                end
            end else if (m_outv) begin
                if (bus.out_ready) begin
                    m_busy = 0;
                    m_outv = 0;
                end
            end else if (m_drain) begin
                m_drain = 0;
                m_outv  = 1;
            end else if (bus.in_valid) begin
                m_pend     = 1;
                m_pend_dot = dot(bus.in_x, bus.in_w);
                m_x        = bus.in_x;
                m_w        = bus.in_w;
                m_left--;
                if (m_left == 0) m_drain = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy",      bus.busy,      m_busy);
            chk("in_ready",  bus.in_ready,  m_busy && !m_outv && !m_drain);
            chk("out_valid", bus.out_valid, m_outv);
            chk("out_data",  bus.out_data,  m_outv ? m_acc : 16'h0);
            chk("mac_psum",  bus.mac_psum,  m_acc);
            chk("mac_x",     bus.mac_x,     m_x);
            chk("mac_w",     bus.mac_w,     m_w);
        end
    end

    // Entered and left at a negedge; returns the cycle of first out_valid (start cycle = 0)
    task automatic run_job(input int n, input int gap_at, input int gap_len, input int hold,
                           input bit start_pulse, output int ov_cyc, output logic [15:0] res);
        int  idx, gapc, held;
        bit  finishing;
        idx = 0; gapc = 0; held = 0; finishing = 0;
        ov_cyc = -1; res = '0;
        bus.len = 8'(n);
        bus.start = 1'b1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        for (int c = 1; c < 300 && !finishing; c++) begin
            bus.start = start_pulse;
            if (bus.out_valid) begin
                if (ov_cyc < 0) begin
                    ov_cyc = c;
                    res = bus.out_data;
                end
                if (held < hold) begin
                    bus.out_ready = 1'b0;
                    held++;
                end else begin
                    bus.out_ready = 1'b1;
                    finishing = 1;
                end
            end
            if (idx < n && gapc == 0) begin
                bus.in_valid = 1'b1;
                bus.in_x = cx[idx];
                bus.in_w = cw[idx];
            end else begin
                bus.in_valid = 1'b0;
                if (gapc > 0) gapc--;
            end
            if (bus.in_valid && bus.in_ready) begin
                if (idx == gap_at) gapc = gap_len;
                idx++;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b0;
        if (!finishing) chk("job_timeout", 32'(ov_cyc), 32'hFFFF_FFFF - 32'd1);
        else chk("idle_after_done", bus.busy, 1'b0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},      bus.busy,      0);
        chk({tag, "_in_ready"},  bus.in_ready,  0);
        chk({tag, "_out_valid"}, bus.out_valid, 0);
        chk({tag, "_out_data"},  bus.out_data,  0);
        chk({tag, "_mac_x"},     bus.mac_x,     0);
        chk({tag, "_mac_w"},     bus.mac_w,     0);
        chk({tag, "_mac_psum"},  bus.mac_psum,  0);
    endtask

    initial begin
        int          ov;
        logic [15:0] res;
        logic [15:0] exp_sum;
        int          n, gap_at, gap_len, exp_cyc;

        total = 0; bad = 0; chk_en = 0;
        reset = 1'b1; tb_bias = '0;
        bus.start = 0; bus.len = '0; bus.in_valid = 0;
        bus.in_x = '0; bus.in_w = '0; bus.out_ready = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1;
        chk_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        // len=1, 1*2 per lane
        cx[0] = 16'h1111; cw[0] = 16'h2222;
        run_job(1, 99, 0, 0, 0, ov, res);
        chk("t1_data", res, 16'd8);
        chk("t1_cycle", ov, 3);

        // len=3 of {1,2,3,4}x{1,1,1,1}, consumer stalls 4 cycles
        for (int i = 0; i < 3; i++) begin cx[i] = 16'h4321; cw[i] = 16'h1111; end
        run_job(3, 99, 0, 4, 0, ov, res);
        chk("t2_data", res, 16'd30);
        chk("t2_cycle", ov, 5);

        // len=2 with a 3-cycle in_valid gap, negative weights
        for (int i = 0; i < 2; i++) begin cx[i] = 16'h2222; cw[i] = 16'hFFFF; end
        run_job(2, 0, 3, 0, 0, ov, res);
        chk("t3_data", res, 16'hFFF0);
        chk("t3_cycle", ov, 7);

        // len=0, then len=1 of ones, with bias -5 where supported
        tb_bias = 16'hFFFB;
        run_job(0, 99, 0, 0, 0, ov, res);
`ifdef MAC_SEQ_BIAS_EN
        chk("t4_len0_data", res, 16'hFFFB);
`else
        chk("t4_len0_data", res, 16'h0000);
`endif
        chk("t4_len0_cycle", ov, 1);
        cx[0] = 16'h1111; cw[0] = 16'h1111;
        run_job(1, 99, 0, 0, 0, ov, res);
`ifdef MAC_SEQ_BIAS_EN
        chk("t4_len1_data", res, 16'hFFFF);
`else
        chk("t4_len1_data", res, 16'h0004);
`endif
        tb_bias = '0;

        // reset after 2 of 4 chunks, then a clean job
        bus.len = 8'd4; bus.start = 1; bus.in_valid = 1;
        bus.in_x = 16'h3333; bus.in_w = 16'h5555;
        @(negedge clk); bus.start = 0;
        @(negedge clk);
        @(negedge clk); reset = 1'b1; bus.in_valid = 0;
        @(negedge clk);
        chk_all_zero("abort");
        reset = 1'b0;
        cx[0] = 16'h1111; cw[0] = 16'h1111;
        run_job(1, 99, 0, 0, 0, ov, res);
        chk("t5_data", res, 16'd4);
        chk("t5_cycle", ov, 3);

        // start held high through RUN and DONE must not launch a second job
        for (int i = 0; i < 3; i++) begin cx[i] = 16'h1357; cw[i] = 16'h9A3F; end
        exp_sum = dot(16'h1357, 16'h9A3F) * 16'd3;
        run_job(3, 99, 0, 2, 1, ov, res);
        chk("t6_data", res, exp_sum);
        chk("t6_cycle", ov, 5);
        @(negedge clk);
        chk("t6_no_second_job", bus.busy, 1'b0);

        // randomized jobs
        for (int j = 0; j < 25; j++) begin
            n       = $urandom_range(0, 6);
            gap_at  = $urandom_range(0, 7);
            gap_len = $urandom_range(0, 3);
`ifdef MAC_SEQ_BIAS_EN
            tb_bias = 16'($urandom);
            exp_sum = tb_bias;
`else
            exp_sum = '0;
`endif
            for (int i = 0; i < n; i++) begin
                cx[i] = 16'($urandom);
                cw[i] = 16'($urandom);
                exp_sum = exp_sum + dot(cx[i], cw[i]);
            end
            exp_cyc = (n == 0) ? 1 : n + 2 + ((gap_at < n - 1) ? gap_len : 0);
            run_job(n, gap_at, gap_len, $urandom_range(0, 3), 1'($urandom), ov, res);
            chk("rand_data", res, exp_sum);
            chk("rand_cycle", ov, exp_cyc);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
